// File: rtl/bsg_noc_links.sv
// Shared link-layout and wormhole-header helpers for the NoC link blocks.
// The link-layout functions take the flit width so that every block derives the same bit positions.
package bsg_noc_links;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_e;

  localparam int link_data_lsb_gp = 0;
  localparam int hdr_cord_lsb_gp  = 0;

  function automatic int link_width(input int flit_width);
    return flit_width + 2;
  endfunction

  function automatic int link_v_bit(input int flit_width);
    return flit_width + 1;
  endfunction

  function automatic int link_ready_bit(input int flit_width);
    return flit_width;
  endfunction

  // len follows directly after the cord field in the header flit
  function automatic int hdr_len_lsb(input int cord_width);
    return hdr_cord_lsb_gp + cord_width;
  endfunction

endpackage

// File: rtl/bsg_arb_rr_pick.sv
// Combinational rotating-priority pick: first requester at or after base_i, wrapping mod els_p.
module bsg_arb_rr_pick #(
  parameter int els_p      = 2,
  parameter int id_width_p = 1
) (
  input  logic [els_p-1:0]      reqs_i,
  input  logic [id_width_p-1:0] base_i,
  output logic [els_p-1:0]      grant_one_hot_o,
  output logic [id_width_p-1:0] grant_id_o,
  output logic                  v_o
);

  int idx;

  // Wrap by subtraction so a non-power-of-2 els_p never yields an index >= els_p
  always_comb begin
    grant_one_hot_o = '0;
    grant_id_o      = '0;
    v_o             = 1'b0;
    idx             = 0;
    for (int i = 0; i < els_p; i++) begin
      idx = int'(base_i) + i;
      if (idx >= els_p) idx = idx - els_p;
      if (!v_o && reqs_i[idx]) begin
        v_o                  = 1'b1;
        grant_id_o           = id_width_p'(idx);
        grant_one_hot_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bsg_wormhole_link_flit_arbiter.sv
// Packet-granular round-robin arbiter: locks one adapter link onto the router port for a whole
// wormhole packet (header + len payload flits); flits pass through combinationally.
module bsg_wormhole_link_flit_arbiter
  import bsg_noc_links::*;
#(
  parameter int els_p        = 2,
  parameter int flit_width_p = 8,
  parameter int len_width_p  = 1,
  parameter int cord_width_p = 1
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic [els_p*(flit_width_p+2)-1:0]     links_i,
  output logic [els_p*(flit_width_p+2)-1:0]     links_o,
  output logic [flit_width_p+1:0]               link_o,
  input  logic [flit_width_p+1:0]               link_i
);

  localparam int lw_lp      = link_width(flit_width_p);
  localparam int v_lp       = link_v_bit(flit_width_p);
  localparam int rdy_lp     = link_ready_bit(flit_width_p);
  localparam int len_lsb_lp = hdr_len_lsb(cord_width_p);
  localparam int id_w_lp    = $clog2(els_p);
  localparam logic [id_w_lp-1:0] last_id_lp = id_w_lp'(els_p - 1);

  arb_state_e               state_r, state_n;
  logic [id_w_lp-1:0]       owner_r, owner_n, rr_r, rr_n, sel;
  logic [len_width_p-1:0]   cnt_r, cnt_n, hlen;
  logic [els_p-1:0]         v, rsvd, grant_oh, pick_one_hot;
  logic [id_w_lp-1:0]       pick_id;
  logic                     pick_v, out_v, ready, xfer;
  logic [flit_width_p-1:0]  data [els_p];
  logic                     unused_bits;

  for (genvar i = 0; i < els_p; i++) begin : g_unpack
    assign v[i]    = links_i[i*lw_lp + v_lp];
    assign rsvd[i] = links_i[i*lw_lp + rdy_lp];
    assign data[i] = links_i[i*lw_lp + link_data_lsb_gp +: flit_width_p];
  end

  assign ready       = link_i[rdy_lp];
  assign unused_bits = ^{rsvd, link_i[v_lp], link_i[link_data_lsb_gp +: flit_width_p]};

  bsg_arb_rr_pick #(.els_p(els_p), .id_width_p(id_w_lp)) pick (
    .reqs_i          (v),
    .base_i          (rr_r),
    .grant_one_hot_o (pick_one_hot),
    .grant_id_o      (pick_id),
    .v_o             (pick_v)
  );

  function automatic logic [id_w_lp-1:0] next_id(input logic [id_w_lp-1:0] id);
    return (id == last_id_lp) ? '0 : id + id_w_lp'(1);
  endfunction

  // Grant selection and next-state; reset gating keeps v/ready low while reset is held
  always_comb begin
    sel      = rr_r;
    out_v    = 1'b0;
    grant_oh = '0;
    state_n  = state_r;
    owner_n  = owner_r;
    cnt_n    = cnt_r;
    rr_n     = rr_r;
    if (state_r == BUSY) begin
      sel               = owner_r;
      out_v             = v[owner_r];
      grant_oh[owner_r] = 1'b1;
    end else begin
      out_v    = pick_v;
      grant_oh = pick_one_hot;
      if (pick_v) sel = pick_id;
    end
    if (!reset_n_i) begin
      out_v    = 1'b0;
      grant_oh = '0;
    end
    hlen = data[sel][len_lsb_lp +: len_width_p];
    xfer = out_v & ready;
    if (xfer) begin
      if (state_r == BUSY) begin
        cnt_n = cnt_r - len_width_p'(1);
        if (cnt_r == len_width_p'(1)) begin
          state_n = IDLE;
          rr_n    = next_id(owner_r);
        end
      end else if (hlen == '0) begin
        rr_n = next_id(sel);
      end else begin
        state_n = BUSY;
        owner_n = sel;
        cnt_n   = hlen;
      end
    end
  end

  always_comb begin
    link_o = '0;
    link_o[v_lp] = out_v;
    link_o[link_data_lsb_gp +: flit_width_p] = data[sel];
    links_o = '0;
    for (int i = 0; i < els_p; i++) links_o[i*lw_lp + rdy_lp] = grant_oh[i] & ready;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
      owner_r <= '0;
      cnt_r   <= '0;
      rr_r    <= '0;
    end else begin
      state_r <= state_n;
      owner_r <= owner_n;
      cnt_r   <= cnt_n;
      rr_r    <= rr_n;
    end
  end

endmodule

// File: tb/tb_bsg_wormhole_link_flit_arbiter.sv
// Scoreboard bench for the wormhole link arbiter (els_p=2, 8-bit flits, len at data[1]).
module tb_bsg_wormhole_link_flit_arbiter;
  import bsg_noc_links::*;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic [19:0] links_i = '0;
  logic [19:0] links_o;
  logic [9:0]  link_o;
  logic [9:0]  link_i = '0;

  int checks = 0;
  int failures = 0;

  logic [7:0] srcq0[$];
  logic [7:0] srcq1[$];
  logic [7:0] expq[$];

  bsg_wormhole_link_flit_arbiter #(
    .els_p(2), .flit_width_p(8), .len_width_p(1), .cord_width_p(1)
  ) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .links_i   (links_i),
    .links_o   (links_o),
    .link_o    (link_o),
    .link_i    (link_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic drive_links(input logic rdy);
    logic v0, v1;
    logic [7:0] d0, d1;
    v0 = srcq0.size() > 0;
    v1 = srcq1.size() > 0;
    d0 = v0 ? srcq0[0] : 8'h00;
    d1 = v1 ? srcq1[0] : 8'h00;
    links_i = {v1, 1'b0, d1, v0, 1'b0, d0};
    link_i  = {1'b0, rdy, 8'h00};
  endtask

  // One clock: drive at negedge, sample 1ns later, retire consumed source flits at posedge
  task automatic cycle(input logic rdy, output logic ov, output logic [7:0] od,
                       output logic r0, output logic r1);
    @(negedge clk_i);
    drive_links(rdy);
    #1;
    ov = link_o[9];
    od = link_o[7:0];
    r0 = links_o[8];
    r1 = links_o[18];
    @(posedge clk_i);
    if (r0 && srcq0.size() > 0) void'(srcq0.pop_front());
    if (r1 && srcq1.size() > 0) void'(srcq1.pop_front());
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    srcq0 = {8'h10};
    srcq1 = {8'h21};
    @(negedge clk_i);
    drive_links(1'b1);
    #1;
    checks++;
    if (link_o[9] !== 1'b0) begin failures++; $display("FAIL reset_v got=%b want=0", link_o[9]); end
    checks++;
    if ({links_o[18], links_o[8]} !== 2'b00) begin
      failures++; $display("FAIL reset_ready got=%b want=00", {links_o[18], links_o[8]});
    end
    reset_n_i = 1'b1;
    #1;
    checks++;
    if (link_o[9:0] !== {1'b1, 1'b0, 8'h10}) begin
      failures++; $display("FAIL first_grant_link got=%h want=%h", link_o, {1'b1, 1'b0, 8'h10});
    end
    checks++;
    if ({links_o[18], links_o[8]} !== 2'b01) begin
      failures++; $display("FAIL first_grant_ready got=%b want=01", {links_o[18], links_o[8]});
    end
    reset_n_i = 1'b0;
    srcq0.delete();
    srcq1.delete();
    links_i = '0;
    link_i  = '0;
    @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  task automatic test_single_packet();
    logic ov, r0, r1;
    logic [7:0] od, exp;
    int xfers = 0;
    srcq1 = {8'h23, 8'hA5};
    expq  = {8'h23, 8'hA5};
    for (int c = 0; c < 10 && expq.size() > 0; c++) begin
      cycle(1'b1, ov, od, r0, r1);
      if (ov) begin
        checks++;
        if (c !== xfers) begin failures++; $display("FAIL single_timing got=%0d want=%0d", c, xfers); end
        xfers++;
        exp = expq.pop_front();
        checks++;
        if (od !== exp) begin failures++; $display("FAIL single_flit got=%h want=%h", od, exp); end
      end
    end
    checks++;
    if (expq.size() !== 0) begin failures++; $display("FAIL single_timeout got=%0d want=0", expq.size()); end
    #1;
    checks++;
    if (dut.state_r !== IDLE) begin failures++; $display("FAIL single_state got=%0d want=IDLE", dut.state_r); end
    checks++;
    if (dut.rr_r !== 1'b0) begin failures++; $display("FAIL single_rr got=%0d want=0", dut.rr_r); end
  endtask

  task automatic test_contention();
    logic ov, r0, r1;
    logic [7:0] od, exp;
    srcq0 = {8'h12, 8'hB0, 8'h12, 8'hB1, 8'h12, 8'hB2};
    srcq1 = {8'h22, 8'hC0, 8'h22, 8'hC1, 8'h22, 8'hC2};
    expq  = {8'h12, 8'hB0, 8'h22, 8'hC0, 8'h12, 8'hB1, 8'h22, 8'hC1, 8'h12, 8'hB2, 8'h22, 8'hC2};
    for (int c = 0; c < 40 && expq.size() > 0; c++) begin
      cycle(1'b1, ov, od, r0, r1);
      checks++;
      if (r0 && r1) begin failures++; $display("FAIL contention_onehot got=11 want<=1 hot"); end
      if (ov) begin
        exp = expq.pop_front();
        checks++;
        if (od !== exp) begin failures++; $display("FAIL contention_flit got=%h want=%h", od, exp); end
      end
    end
    checks++;
    if (expq.size() !== 0) begin failures++; $display("FAIL contention_timeout got=%0d want=0", expq.size()); end
  endtask

  task automatic test_backpressure();
    logic ov, r0, r1, rdy;
    logic [7:0] od, exp;
    logic [3:0] rdyseq;
    rdyseq = 4'b1001;
    srcq0 = {8'h12, 8'hD5};
    srcq1 = {8'h22, 8'hE6};
    expq  = {8'h12, 8'hD5, 8'h22, 8'hE6};
    for (int c = 0; c < 20 && expq.size() > 0; c++) begin
      rdy = (c < 4) ? rdyseq[3-c] : 1'b1;
      cycle(rdy, ov, od, r0, r1);
      if (c == 1 || c == 2) begin
        checks++;
        if ({ov, od} !== {1'b1, 8'hD5}) begin
          failures++; $display("FAIL stall_hold got=%b/%h want=1/d5", ov, od);
        end
      end
      if (c == 3) begin
        checks++;
        if ({r1, r0} !== 2'b01) begin failures++; $display("FAIL lock_ready got=%b want=01", {r1, r0}); end
      end
      if (ov && rdy) begin
        exp = expq.pop_front();
        checks++;
        if (od !== exp) begin failures++; $display("FAIL bp_flit got=%h want=%h", od, exp); end
      end
    end
    checks++;
    if (expq.size() !== 0) begin failures++; $display("FAIL bp_timeout got=%0d want=0", expq.size()); end
  endtask

  task automatic test_len0();
    logic ov, r0, r1;
    logic [7:0] od, exp;
    srcq0 = {8'h40, 8'h44, 8'h48};
    srcq1 = {8'h50, 8'h54, 8'h58};
    expq  = {8'h40, 8'h50, 8'h44, 8'h54, 8'h48, 8'h58};
    for (int c = 0; c < 20 && expq.size() > 0; c++) begin
      cycle(1'b1, ov, od, r0, r1);
      if (ov) begin
        exp = expq.pop_front();
        checks++;
        if (od !== exp) begin failures++; $display("FAIL len0_flit got=%h want=%h", od, exp); end
      end
      #1;
      checks++;
      if (dut.state_r !== IDLE) begin failures++; $display("FAIL len0_state got=%0d want=IDLE", dut.state_r); end
    end
    checks++;
    if (expq.size() !== 0) begin failures++; $display("FAIL len0_timeout got=%0d want=0", expq.size()); end
  endtask

  task automatic test_mid_reset();
    logic ov, r0, r1;
    logic [7:0] od, exp;
    srcq0 = {8'h40};
    srcq1 = {8'h22, 8'hF1};
    expq  = {8'h40, 8'h22};
    for (int c = 0; c < 6 && expq.size() > 0; c++) begin
      cycle(1'b1, ov, od, r0, r1);
      if (ov) begin
        exp = expq.pop_front();
        checks++;
        if (od !== exp) begin failures++; $display("FAIL midrst_flit got=%h want=%h", od, exp); end
      end
    end
    checks++;
    if (expq.size() !== 0) begin failures++; $display("FAIL midrst_timeout got=%0d want=0", expq.size()); end
    #1;
    checks++;
    if (dut.state_r !== BUSY) begin failures++; $display("FAIL midrst_busy got=%0d want=BUSY", dut.state_r); end
    @(negedge clk_i);
    drive_links(1'b1);
    reset_n_i = 1'b0;
    #1;
    checks++;
    if ({link_o[9], links_o[18], links_o[8]} !== 3'b000) begin
      failures++; $display("FAIL midrst_outputs got=%b want=000", {link_o[9], links_o[18], links_o[8]});
    end
    srcq0.delete();
    srcq1.delete();
    links_i = '0;
    @(negedge clk_i);
    reset_n_i = 1'b1;
    #1;
    checks++;
    if (dut.state_r !== IDLE) begin failures++; $display("FAIL midrst_state got=%0d want=IDLE", dut.state_r); end
    checks++;
    if (dut.rr_r !== 1'b0) begin failures++; $display("FAIL midrst_rr got=%0d want=0", dut.rr_r); end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_contention();
    test_backpressure();
    test_len0();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
